// File: rtl/regfile_wb_sched.sv
// Writeback scheduler for the register file.
// Accepted {dstE, valE, dstM, valM} bundles are queued in a small FIFO and
// drained as at most one registered write per cycle, E before M. A 2-bit
// pending counter per register feeds the decode-stage hazard outputs. The
// counter is raised when a bundle is accepted and lowered when its write
// retires.
module regfile_wb_sched #(
   parameter int n     = 64,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   dstE,
   input  logic [n-1:0] valE,
   input  logic [3:0]   dstM,
   input  logic [n-1:0] valM,
   output logic         wr_en,
   output logic [3:0]   wr_addr,
   output logic [n-1:0] wr_data,
   input  logic [3:0]   srcA,
   input  logic [3:0]   srcB,
   output logic         hazA,
   output logic         hazB
);

   localparam int         AW    = $clog2(DEPTH);
   localparam logic [3:0] RNONE = 4'hF;

   typedef struct packed {
      logic [3:0]   dst_e;
      logic [n-1:0] val_e;
      logic [3:0]   dst_m;
      logic [n-1:0] val_m;
   } bundle_t;

   typedef enum logic {
      HEAD_E,
      HEAD_M
   } state_t;

   // Bundle FIFO
   bundle_t       fifo_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;
   bundle_t       head;

   // Head decode
   logic          head_need_e;
   logic          head_need_m;
   logic          issue;
   logic [3:0]    issue_addr;
   logic [n-1:0]  issue_data;
   state_t        state_d;

   // Write port and scheduler state
   state_t        state_q;
   logic          wr_en_q;
   logic [3:0]    wr_addr_q;
   logic [n-1:0]  wr_data_q;

   // Pending-write counters for registers 0..14
   logic [1:0]    cnt_q [15];
   logic [1:0]    cnt_d [15];

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (AW + 1)'(DEPTH));
   assign in_ready   = !fifo_full;
   assign push       = in_valid && in_ready;
   assign head       = fifo_q[rd_ptr_q];

   // An E write that names the same register as M is dropped: M wins.
   assign head_need_e = (head.dst_e != RNONE) && (head.dst_e != head.dst_m);
   assign head_need_m = (head.dst_m != RNONE);

   // Storage for accepted bundles; only the pointers and count are reset.
   // NOTE: memory arrays are left out of reset; the empty count already marks every entry invalid, and resetting them would only add reset fan-out.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= '{dst_e: dstE, val_e: valE, dst_m: dstM, val_m: valM};
      end
   end

   // FIFO pointers and occupancy; push and pop may happen on the same edge.
   // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values, whatever order the blocks are evaluated in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW + 1)'(push) - (AW + 1)'(pop);
      end
   end

   // Choose this cycle's write from the head bundle and decide whether it pops.
   // NOTE: every output of a combinational block gets a default first, so no path leaves a value unassigned and infers a latch.
   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      issue_addr = wr_addr_q;
      issue_data = wr_data_q;
      pop        = 1'b0;
      if (!fifo_empty) begin
         case (state_q)
            HEAD_E: begin
               if (head_need_e) begin
                  issue      = 1'b1;
                  issue_addr = head.dst_e;
                  issue_data = head.val_e;
                  if (head_need_m) state_d = HEAD_M;
                  else             pop     = 1'b1;
               end else begin
                  // Skip E in the same cycle; a null bundle pops with no write.
                  if (head_need_m) begin
                     issue      = 1'b1;
                     issue_addr = head.dst_m;
                     issue_data = head.val_m;
                  end
                  pop = 1'b1;
               end
            end
            HEAD_M: begin
               if (head_need_m) begin
                  issue      = 1'b1;
                  issue_addr = head.dst_m;
                  issue_data = head.val_m;
               end
               pop     = 1'b1;
               state_d = HEAD_E;
            end
            default: state_d = HEAD_E;
         endcase
      end
   end

   // Scheduler state and registered write port; address and data hold when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HEAD_E;
         wr_en_q   <= 1'b0;
         wr_addr_q <= RNONE;
         wr_data_q <= '0;
      end else begin
         state_q <= state_d;
         wr_en_q <= issue;
         if (issue) begin
            wr_addr_q <= issue_addr;
            wr_data_q <= issue_data;
         end
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;

   // Counter update: up on accept per distinct valid dst, down when a write retires.
   always_comb begin
      for (int r = 0; r < 15; r++) begin
         cnt_d[r] = cnt_q[r];
         if ((push && (((dstE == 4'(r)) && (dstE != dstM)) || (dstM == 4'(r))))
             && !(wr_en_q && (wr_addr_q == 4'(r)))) begin
            cnt_d[r] = cnt_q[r] + 2'd1;
         end else if (!(push && (((dstE == 4'(r)) && (dstE != dstM)) || (dstM == 4'(r))))
                      && (wr_en_q && (wr_addr_q == 4'(r)))) begin
            cnt_d[r] = cnt_q[r] - 2'd1;
         end
      end
   end

   // Pending-write counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < 15; r++) cnt_q[r] <= '0;
      end else begin
         for (int r = 0; r < 15; r++) cnt_q[r] <= cnt_d[r];
      end
   end

   // Decode hazards; RNONE never has a pending write.
   always_comb begin
      hazA = 1'b0;
      hazB = 1'b0;
      if (srcA != RNONE) hazA = (cnt_q[srcA] != 2'd0);
      if (srcB != RNONE) hazB = (cnt_q[srcB] != 2'd0);
   end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: a driver process offers queued bundles, the
// expected writes of each accepted bundle go into a scoreboard queue, and a
// monitor pops and compares every write and checks both hazard outputs
// against the set of writes that have not yet retired.
module tb_regfile_wb_sched;

   localparam int         N     = 64;
   localparam int         DEPTH = 2;
   localparam logic [3:0] RN    = 4'hF;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [3:0]   dstE = RN;
   logic [N-1:0] valE = '0;
   logic [3:0]   dstM = RN;
   logic [N-1:0] valM = '0;
   logic         wr_en;
   logic [3:0]   wr_addr;
   logic [N-1:0] wr_data;
   logic [3:0]   srcA = RN;
   logic [3:0]   srcB = RN;
   logic         hazA;
   logic         hazB;

   regfile_wb_sched #(.n(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .srcA(srcA), .srcB(srcB), .hazA(hazA), .hazB(hazB)
   );

   always #5 clk = ~clk;

   typedef struct { logic [3:0] a; logic [N-1:0] d; } wr_t;
   typedef struct { logic [3:0] de; logic [N-1:0] ve; logic [3:0] dm; logic [N-1:0] vm; } bnd_t;

   wr_t  exp_q[$];
   bnd_t stim_q[$];
   int   acc_log[$];
   int   wr_log[$];
   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   bit   have = 1'b0;
   bit   gaps = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
   endtask

   task automatic fail_note(input string name, input string what);
      checks++;
      $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
   endtask

   // A register is hazardous while any accepted write to it has not retired.
   function automatic logic model_haz(input logic [3:0] s);
      if (s == RN) return 1'b0;
      foreach (exp_q[i]) if (exp_q[i].a == s) return 1'b1;
      return 1'b0;
   endfunction

   // Writes a bundle must produce: E unless absent or overridden by M, then M.
   function automatic void expect_bundle(input bnd_t b);
      wr_t w;
      if (b.de != RN && b.de != b.dm) begin
         w.a = b.de; w.d = b.ve; exp_q.push_back(w);
      end
      if (b.dm != RN) begin
         w.a = b.dm; w.d = b.vm; exp_q.push_back(w);
      end
   endfunction

   function automatic logic [3:0] rnd_reg();
      int r;
      r = $urandom_range(0, 6);
      return (r == 6) ? RN : 4'(r);
   endfunction

   task automatic send(input logic [3:0] de, input logic [N-1:0] ve,
                       input logic [3:0] dm, input logic [N-1:0] vm);
      bnd_t b;
      b.de = de; b.ve = ve; b.dm = dm; b.vm = vm;
      stim_q.push_back(b);
   endtask

   // Driver: offer one bundle at a time, hold it until accepted.
   initial begin
      bnd_t cur;
      bit   take;
      cur = '{RN, '0, RN, '0};
      forever begin
         @(negedge clk);
         if (!have && stim_q.size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
            cur  = stim_q.pop_front();
            have = 1'b1;
         end
         in_valid = have;
         dstE = cur.de; valE = cur.ve; dstM = cur.dm; valM = cur.vm;
         take = have && in_ready && rst_n;
         @(posedge clk);
         #1;
         if (take) begin
            expect_bundle(cur);
            acc_log.push_back(cyc);
            have = 1'b0;
         end
      end
   end

   // Monitor: hazards against pending writes, then the write itself.
   initial begin
      wr_t w;
      forever begin
         @(negedge clk);
         check("hazA", N'(hazA), N'(model_haz(srcA)));
         check("hazB", N'(hazB), N'(model_haz(srcB)));
         if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               fail_note("unexpected_write", $sformatf("got addr %0h data %0h, expected no write", wr_addr, wr_data));
            end else begin
               w = exp_q.pop_front();
               check("wr_addr", N'(wr_addr), N'(w.a));
               check("wr_data", wr_data, w.d);
            end
            wr_log.push_back(cyc);
         end
         srcA = rnd_reg();
         srcB = rnd_reg();
      end
   end

   task automatic wait_idle(input int bound);
      for (int k = 0; k < bound; k++) begin
         @(negedge clk);
         #1;
         if (stim_q.size() == 0 && !have && exp_q.size() == 0) begin
            repeat (2) @(negedge clk);
            #1;
            return;
         end
      end
      fail_note("drain_timeout", $sformatf("%0d writes still expected", exp_q.size()));
   endtask

   task automatic clear_logs();
      acc_log.delete();
      wr_log.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_wr_en", N'(wr_en), N'(1'b0));
      check("rst_wr_addr", N'(wr_addr), N'(RN));
      check("rst_wr_data", wr_data, '0);
      check("rst_in_ready", N'(in_ready), N'(1'b1));
      @(negedge clk);
      rst_n = 1'b1;

      // Single E write: one write the cycle after accept
      clear_logs();
      send(4'd3, N'(500), RN, '0);
      wait_idle(50);
      check("single_e_count", N'(wr_log.size()), N'(1));
      if (wr_log.size() >= 1 && acc_log.size() >= 1)
         check("single_e_latency", N'(wr_log[0] - acc_log[0]), N'(1));

      // Dual write: E then M on consecutive cycles
      clear_logs();
      send(4'd4, N'(250), 4'd7, N'(251));
      wait_idle(50);
      check("dual_count", N'(wr_log.size()), N'(2));
      if (wr_log.size() >= 2 && acc_log.size() >= 1) begin
         check("dual_lat_e", N'(wr_log[0] - acc_log[0]), N'(1));
         check("dual_lat_m", N'(wr_log[1] - acc_log[0]), N'(2));
      end

      // Collapse E==M: single M write, port holds afterwards
      clear_logs();
      send(4'd4, N'(8), 4'd4, N'(16));
      wait_idle(50);
      check("collapse_count", N'(wr_log.size()), N'(1));
      check("hold_wr_en", N'(wr_en), N'(1'b0));
      check("hold_wr_addr", N'(wr_addr), N'(4));
      check("hold_wr_data", wr_data, N'(16));

      // Null bundle drains in one cycle, next bundle follows directly
      clear_logs();
      send(RN, N'(1), RN, N'(2));
      send(4'd5, N'(77), RN, '0);
      wait_idle(50);
      check("null_count", N'(wr_log.size()), N'(1));
      if (wr_log.size() >= 1 && acc_log.size() >= 2) begin
         check("null_accept_gap", N'(acc_log[1] - acc_log[0]), N'(1));
         check("null_then_write", N'(wr_log[0] - acc_log[0]), N'(2));
      end

      // Back-to-back single writes: no bubbles
      clear_logs();
      for (int i = 0; i < 4; i++) send(4'(i), N'(100 + i), RN, '0);
      wait_idle(50);
      check("b2b_count", N'(wr_log.size()), N'(4));
      if (wr_log.size() >= 4)
         check("b2b_span", N'(wr_log[3] - wr_log[0]), N'(3));

      // Backpressure: three dual bundles offered every cycle
      clear_logs();
      for (int i = 0; i < 3; i++) send(4'(2 * i), N'(10 * i), 4'(2 * i + 1), N'(10 * i + 1));
      wait_idle(50);
      check("bp_count", N'(wr_log.size()), N'(6));
      if (acc_log.size() >= 3) begin
         check("bp_accept_2", N'(acc_log[1] - acc_log[0]), N'(1));
         check("bp_accept_3", N'(acc_log[2] - acc_log[0]), N'(3));
      end
      if (wr_log.size() >= 6 && acc_log.size() >= 1) begin
         check("bp_first_write", N'(wr_log[0] - acc_log[0]), N'(1));
         check("bp_no_gaps", N'(wr_log[5] - wr_log[0]), N'(5));
      end

      // Reset between the E and M writes
      clear_logs();
      send(4'd1, N'(9), 4'd2, N'(10));
      for (int k = 0; k < 20 && wr_log.size() == 0; k++) begin
         @(negedge clk);
         #1;
      end
      if (wr_log.size() == 0) fail_note("rst_mid_e_write", "E write never appeared");
      check("rst_mid_e_addr", N'(wr_addr), N'(1));
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("rst_mid_wr_en", N'(wr_en), N'(1'b0));
      check("rst_mid_in_ready", N'(in_ready), N'(1'b1));
      check("rst_mid_hazA", N'(hazA), N'(1'b0));
      check("rst_mid_hazB", N'(hazB), N'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      check("rst_mid_no_m", N'(wr_log.size()), N'(1));
      check("rst_mid_ready_after", N'(in_ready), N'(1'b1));

      // Randomized traffic with input gaps
      gaps = 1'b1;
      for (int i = 0; i < 300; i++) send(rnd_reg(), {$urandom, $urandom}, rnd_reg(), {$urandom, $urandom});
      wait_idle(3000);
      check("final_queue_empty", N'(exp_q.size()), N'(0));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_sched.md
REGFILE_WB_SCHED -- requirements
Module: regfile_wb_sched

Interface
REQ-001 SHALL have parameter n, default 64, meaning data width of valE/valM and the write port.
REQ-002 SHALL have parameter DEPTH, default 2, meaning bundle FIFO depth in entries (power of two, at least 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  writeback bundle offered.
REQ-006 in_ready  output  1  bundle accepted on an edge where in_valid && in_ready.
REQ-007 dstE  input  4  register ID for valE; 4'hF = RNONE (no write).
REQ-008 valE  input  n  E-result data.
REQ-009 dstM  input  4  register ID for valM; 4'hF = RNONE.
REQ-010 valM  input  n  M-result data.
REQ-011 wr_en  output  1  registered write strobe to the register file; regfile writes on the next rising edge.
REQ-012 wr_addr  output  4  registered write register ID.
REQ-013 wr_data  output  n  registered write data.
REQ-014 srcA, srcB  input  4 each  decode read IDs to check against pending writes.
REQ-015 hazA, hazB  output  1 each  combinational; high when the matching src has an outstanding write.

Function
REQ-016 SHALL buffer accepted bundles {dstE, valE, dstM, valM} in a DEPTH-entry FIFO; in_ready = FIFO not full (combinational, no dependence on in_valid).
REQ-017 SHALL issue at most one register write per cycle; head bundle write order is E then M.
REQ-018 Per head bundle: state HEAD_E issues E if dstE != F, otherwise skips to HEAD_M in the same cycle; HEAD_M issues M if dstM != F, then pops the bundle and returns to HEAD_E.
REQ-019 SHALL treat a bundle with both dst = F as a zero-write bundle: pop it in one cycle with wr_en low.
REQ-020 SHALL issue only valM when dstE == dstM != F (M wins, popq %rsp semantics); that bundle takes one write cycle.
REQ-021 Latency: bundle accepted at edge T into an empty FIFO gives wr_en=1 with the first write after edge T+1; a two-write bundle gives writes after edges T+1 and T+2.
REQ-022 Back-to-back single-write bundles SHALL sustain one write per cycle with no bubbles.
REQ-023 Simultaneous push and pop on a full FIFO SHALL be disallowed (in_ready low when full), and a pop SHALL free the slot for the next cycle.
REQ-024 SHALL keep a 2-bit pending counter per register 0..14: increment on accept for each valid dst (a collapsed E==M counts once), and decrement on the edge that retires a write (the edge after the wr_en=1 cycle).
REQ-025 Same-register increment and decrement on one edge SHALL leave the counter unchanged.
REQ-026 hazX = (srcX != F) && (cnt[srcX] != 0); srcX = F SHALL always yield hazX = 0.
REQ-027 Counters SHALL NOT overflow: DEPTH <= 2 bounds each counter to at most 2 (one E and one M per bundle, collapsed when equal).
REQ-028 wr_en SHALL be low in every cycle with no write issued; wr_addr and wr_data then hold their last values.

Reset
REQ-029 rst_n low SHALL immediately clear the FIFO, all pending counters and wr_en, set state to HEAD_E and set wr_addr = 4'hF, wr_data = 0, independent of clk.
REQ-030 Reset mid-bundle SHALL discard any unissued writes; in_ready = 1 and haz = 0 from the deassertion edge onward.
REQ-031 Deassertion SHALL be taken as synchronous to clk; the first accept can occur on the first rising edge after deassertion.

Verification
REQ-032 Single E: dstE=3 valE=500 dstM=F accepted at edge T -> wr_en/wr_addr=3/wr_data=500 for one cycle after T+1; hazB(srcB=3)=1 from after T through retirement, then 0.
REQ-033 Dual write: dstE=4 valE=250 dstM=7 valM=251 -> write (4,250), then (7,251) on consecutive cycles; hazA for src 7 stays high one cycle longer than for src 4.
REQ-034 Collapse: dstE=dstM=4 valE=8 valM=16 -> exactly one write (4,16); cnt[4] goes to 1, then back to 0.
REQ-035 Backpressure: three dual-write bundles offered every cycle with DEPTH=2 -> in_ready drops after two accepts, six writes appear in order with no gaps, and no bundle is lost.
REQ-036 Reset mid-bundle: rst_n pulled low between the E and M writes of (dstE=1 valE=9, dstM=2 valM=10) -> wr_en=0 at once, no write to reg 2, hazards 0, in_ready=1.
REQ-037 Null bundle and srcX=F: dstE=dstM=F -> no wr_en, FIFO drains in one cycle; srcA=F -> hazA=0 at all times.
